// File: rtl/mem_stage_mc.sv
// rtl/mem_stage_mc.sv - multi-cycle MEM pipeline stage with sub-word loads/stores
//
// Sits between the EX/MEM and MEM/WB pipeline registers and owns the data memory.
// Each aligned load/store takes LATENCY cycles; the stage stalls the pipeline
// through the hazard detection unit while the access is in flight.
//
// Ports:
//   clk, rst_n, en                  clock, sync active-low reset, stage enable
//   stage_EX_MEM__MEM_*             EX/MEM register fields (control, funct3,
//                                   address/ALU result, store data, rd)
//   MEM__HDUbr_memread, MEM__EX_for_help, MEM__FUbr_rd_id, MEM__FU_FUbr_regwrite
//                                   combinational copies for HDU/forwarding
//   MEM__HDU_stall                  access in flight, upstream must hold inputs
//   MEM__misalign                   registered one-cycle misaligned-access pulse
//   stage_MEM_WB__WB_*              registered MEM/WB fields
module mem_stage_mc #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            stage_EX_MEM__MEM_regwrite,
  input  logic            stage_EX_MEM__MEM_memtoreg,
  input  logic            stage_EX_MEM__MEM_memread,
  input  logic            stage_EX_MEM__MEM_memwrite,
  input  logic [2:0]      stage_EX_MEM__MEM_funct3,
  input  logic [XLEN-1:0] stage_EX_MEM__MEM_alures,
  input  logic [XLEN-1:0] stage_EX_MEM__MEM_store_data,
  input  logic [4:0]      stage_EX_MEM__MEM_rd_id,
  output logic            MEM__HDUbr_memread,
  output logic [XLEN-1:0] MEM__EX_for_help,
  output logic [4:0]      MEM__FUbr_rd_id,
  output logic            MEM__FU_FUbr_regwrite,
  output logic            MEM__HDU_stall,
  output logic            MEM__misalign,
  output logic            stage_MEM_WB__WB_memtoreg,
  output logic            stage_MEM_WB__WB_regwrite,
  output logic [XLEN-1:0] stage_MEM_WB__WB_memdata,
  output logic [XLEN-1:0] stage_MEM_WB__WB_regdata,
  output logic [4:0]      stage_MEM_WB__WB_rd_id
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // cnt only ever reaches LATENCY-1
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Forwarding / HDU copies: pure wires, independent of en and stall
  // ---------------------------------------------------------------------------
  assign MEM__HDUbr_memread    = stage_EX_MEM__MEM_memread;
  assign MEM__EX_for_help      = stage_EX_MEM__MEM_alures;
  assign MEM__FUbr_rd_id       = stage_EX_MEM__MEM_rd_id;
  assign MEM__FU_FUbr_regwrite = stage_EX_MEM__MEM_regwrite;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic [1:0]    boff;
  logic [AW-1:0] widx;
  logic          is_byte, is_half, is_word;
  logic          memop, misaligned, aligned_op, bad_op;

  assign boff    = stage_EX_MEM__MEM_alures[1:0];
  assign widx    = stage_EX_MEM__MEM_alures[AW+1:2];
  // funct3[1] set covers 010 plus the reserved 011/110/111, all handled as word
  assign is_word = stage_EX_MEM__MEM_funct3[1];
  assign is_half = (stage_EX_MEM__MEM_funct3[1:0] == 2'b01);
  assign is_byte = (stage_EX_MEM__MEM_funct3[1:0] == 2'b00);

  assign memop      = en & (stage_EX_MEM__MEM_memread | stage_EX_MEM__MEM_memwrite);
  assign misaligned = (is_half & boff[0]) | (is_word & (boff != 2'b00));
  assign aligned_op = memop & ~misaligned;
  assign bad_op     = memop & misaligned;

  // Access completes at the coming edge; rst_n gating aborts a pending store
  logic complete;
  always_comb begin
    complete = 1'b0;
    if (rst_n && en) begin
      if (state == IDLE)
        complete = aligned_op && (LATENCY == 1);
      else
        complete = (cnt == CNT_LAST);
    end
  end

  // Stall is a function of registered state plus the (en-gated) memop, so with
  // en=0 it simply reflects the frozen FSM.
  always_comb begin
    MEM__HDU_stall = 1'b0;
    if (rst_n) begin
      if (state == IDLE)
        MEM__HDU_stall = aligned_op && (LATENCY > 1);
      else
        MEM__HDU_stall = (cnt < CNT_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Store lane enables and lane-replicated write data
  // ---------------------------------------------------------------------------
  logic [3:0]      wr_be;
  logic [XLEN-1:0] wr_data;
  logic            do_write;

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = stage_EX_MEM__MEM_store_data;
    if (is_byte) begin
      wr_be   = 4'b0001 << boff;
      wr_data = {4{stage_EX_MEM__MEM_store_data[7:0]}};
    end else if (is_half) begin
      wr_be   = boff[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{stage_EX_MEM__MEM_store_data[15:0]}};
    end
  end

  assign do_write = complete & stage_EX_MEM__MEM_memwrite;

  // Memory contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load lane select and extension
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] load_data;

  assign rd_word = mem[widx];
  assign rd_byte = rd_word[{boff, 3'b000} +: 8];
  assign rd_half = boff[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (stage_EX_MEM__MEM_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM, counter and MEM/WB register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                     <= IDLE;
      cnt                       <= '0;
      MEM__misalign             <= 1'b0;
      stage_MEM_WB__WB_memtoreg <= 1'b0;
      stage_MEM_WB__WB_regwrite <= 1'b0;
      stage_MEM_WB__WB_memdata  <= '0;
      stage_MEM_WB__WB_regdata  <= '0;
      stage_MEM_WB__WB_rd_id    <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (aligned_op && (LATENCY > 1)) begin
            state <= BUSY;
            cnt   <= CW'(1);
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      MEM__misalign <= bad_op;

      if (MEM__HDU_stall) begin
        // Bubble: kill the writeback, keep the data fields as they were
        stage_MEM_WB__WB_regwrite <= 1'b0;
        stage_MEM_WB__WB_memtoreg <= 1'b0;
      end else begin
        stage_MEM_WB__WB_memtoreg <= stage_EX_MEM__MEM_memtoreg;
        stage_MEM_WB__WB_regwrite <= stage_EX_MEM__MEM_regwrite & ~bad_op;
        stage_MEM_WB__WB_regdata  <= stage_EX_MEM__MEM_alures;
        stage_MEM_WB__WB_rd_id    <= stage_EX_MEM__MEM_rd_id;
        stage_MEM_WB__WB_memdata  <= (complete && stage_EX_MEM__MEM_memread)
                                     ? load_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// tb/tb_mem_stage_mc.sv - scoreboard bench for mem_stage_mc at LATENCY 1 and 3
module tb_mem_stage_mc;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] alures;
    logic [31:0] sdata;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    int          cyc;
    int          which;
    int          field;
    logic [31:0] val;
    string       name;
  } exp_t;

  localparam int F_RW = 0, F_MTR = 1, F_MD = 2, F_RDAT = 3, F_RD = 4,
                 F_MIS = 5, F_STALL = 6, F_FHELP = 7, F_FRD = 8, F_FMR = 9,
                 F_FRW = 10;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  op_t  op   [2];
  logic en   [2];
  logic rstn [2];

  logic        hdu_mr [2];
  logic [31:0] fhelp  [2];
  logic [4:0]  frd    [2];
  logic        frw    [2];
  logic        stall  [2];
  logic        mis    [2];
  logic        wb_mtr [2];
  logic        wb_rw  [2];
  logic [31:0] wb_md  [2];
  logic [31:0] wb_rdat[2];
  logic [4:0]  wb_rd  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_mc #(.XLEN(32), .DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rstn[0]), .en(en[0]),
    .stage_EX_MEM__MEM_regwrite(op[0].regwrite),
    .stage_EX_MEM__MEM_memtoreg(op[0].memtoreg),
    .stage_EX_MEM__MEM_memread(op[0].memread),
    .stage_EX_MEM__MEM_memwrite(op[0].memwrite),
    .stage_EX_MEM__MEM_funct3(op[0].funct3),
    .stage_EX_MEM__MEM_alures(op[0].alures),
    .stage_EX_MEM__MEM_store_data(op[0].sdata),
    .stage_EX_MEM__MEM_rd_id(op[0].rd),
    .MEM__HDUbr_memread(hdu_mr[0]), .MEM__EX_for_help(fhelp[0]),
    .MEM__FUbr_rd_id(frd[0]), .MEM__FU_FUbr_regwrite(frw[0]),
    .MEM__HDU_stall(stall[0]), .MEM__misalign(mis[0]),
    .stage_MEM_WB__WB_memtoreg(wb_mtr[0]), .stage_MEM_WB__WB_regwrite(wb_rw[0]),
    .stage_MEM_WB__WB_memdata(wb_md[0]), .stage_MEM_WB__WB_regdata(wb_rdat[0]),
    .stage_MEM_WB__WB_rd_id(wb_rd[0])
  );

  mem_stage_mc #(.XLEN(32), .DEPTH_WORDS(256), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rstn[1]), .en(en[1]),
    .stage_EX_MEM__MEM_regwrite(op[1].regwrite),
    .stage_EX_MEM__MEM_memtoreg(op[1].memtoreg),
    .stage_EX_MEM__MEM_memread(op[1].memread),
    .stage_EX_MEM__MEM_memwrite(op[1].memwrite),
    .stage_EX_MEM__MEM_funct3(op[1].funct3),
    .stage_EX_MEM__MEM_alures(op[1].alures),
    .stage_EX_MEM__MEM_store_data(op[1].sdata),
    .stage_EX_MEM__MEM_rd_id(op[1].rd),
    .MEM__HDUbr_memread(hdu_mr[1]), .MEM__EX_for_help(fhelp[1]),
    .MEM__FUbr_rd_id(frd[1]), .MEM__FU_FUbr_regwrite(frw[1]),
    .MEM__HDU_stall(stall[1]), .MEM__misalign(mis[1]),
    .stage_MEM_WB__WB_memtoreg(wb_mtr[1]), .stage_MEM_WB__WB_regwrite(wb_rw[1]),
    .stage_MEM_WB__WB_memdata(wb_md[1]), .stage_MEM_WB__WB_regdata(wb_rdat[1]),
    .stage_MEM_WB__WB_rd_id(wb_rd[1])
  );

  function automatic op_t mk(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] rd);
    op_t o;
    o.regwrite = rd_en;
    o.memtoreg = rd_en;
    o.memread  = rd_en;
    o.memwrite = wr_en;
    o.funct3   = f3;
    o.alures   = addr;
    o.sdata    = data;
    o.rd       = rd;
    return o;
  endfunction

  function automatic logic [31:0] act(input int w, input int f);
    case (f)
      F_RW:    return {31'd0, wb_rw[w]};
      F_MTR:   return {31'd0, wb_mtr[w]};
      F_MD:    return wb_md[w];
      F_RDAT:  return wb_rdat[w];
      F_RD:    return {27'd0, wb_rd[w]};
      F_MIS:   return {31'd0, mis[w]};
      F_STALL: return {31'd0, stall[w]};
      F_FHELP: return fhelp[w];
      F_FRD:   return {27'd0, frd[w]};
      F_FMR:   return {31'd0, hdu_mr[w]};
      default: return {31'd0, frw[w]};
    endcase
  endfunction

  // Expectation for DUT w, d cycles after the current one
  task automatic expect_at(input int w, input int d, input int f,
                           input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + d; e.which = w; e.field = f; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops every expectation due this cycle, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [31:0] a;
        a = act(sb[i].which, sb[i].field);
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s (L%0d): expectation for cycle %0d missed", sb[i].name,
                   sb[i].which ? 3 : 1, sb[i].cyc);
        end else if (a !== sb[i].val) begin
          errors++;
          $display("FAIL %s (L%0d) cycle %0d: got 0x%08h expected 0x%08h", sb[i].name,
                   sb[i].which ? 3 : 1, cyc, a, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      op[w] = '0; en[w] = 1'b1; rstn[w] = 1'b0;
    end
    step(); step();
    for (int w = 0; w < 2; w++) begin
      expect_at(w, 0, F_RW,    0, "reset_regwrite");
      expect_at(w, 0, F_MD,    0, "reset_memdata");
      expect_at(w, 0, F_RDAT,  0, "reset_regdata");
      expect_at(w, 0, F_RD,    0, "reset_rd");
      expect_at(w, 0, F_MIS,   0, "reset_misalign");
      expect_at(w, 0, F_STALL, 0, "reset_stall");
    end
    step();
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // ---------------- LATENCY = 1 ----------------
    op[0] = mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    expect_at(0, 0, F_STALL, 0, "l1_sw_stall");
    step();
    op[0] = mk(1, 0, 3'b010, 32'h10, 0, 3);
    expect_at(0, 0, F_STALL, 0, "l1_lw_stall");
    expect_at(0, 1, F_MD, 32'hDEADBEEF, "l1_lw_data");
    expect_at(0, 1, F_RW, 1, "l1_lw_regwrite");
    expect_at(0, 1, F_RD, 3, "l1_lw_rd");
    step();
    op[0] = mk(0, 1, 3'b000, 32'h13, 32'h80, 0);
    step();
    op[0] = mk(1, 0, 3'b000, 32'h13, 0, 4);
    expect_at(0, 1, F_MD, 32'hFFFFFF80, "l1_lb");
    step();
    op[0] = mk(1, 0, 3'b100, 32'h13, 0, 4);
    expect_at(0, 1, F_MD, 32'h00000080, "l1_lbu");
    step();
    op[0] = mk(1, 0, 3'b001, 32'h12, 0, 4);
    expect_at(0, 1, F_MD, 32'hFFFF80AD, "l1_lh");
    step();
    op[0] = mk(1, 0, 3'b101, 32'h12, 0, 4);
    expect_at(0, 1, F_MD, 32'h000080AD, "l1_lhu");
    step();
    op[0] = mk(1, 0, 3'b010, 32'h11, 0, 6);
    expect_at(0, 0, F_STALL, 0, "l1_mis_lw_stall");
    expect_at(0, 1, F_MIS, 1, "l1_mis_lw_pulse");
    expect_at(0, 1, F_RW, 0, "l1_mis_lw_regwrite");
    expect_at(0, 1, F_MD, 0, "l1_mis_lw_memdata");
    step();
    op[0] = mk(0, 1, 3'b001, 32'h11, 32'hFFFFFFFF, 0);
    expect_at(0, 1, F_MIS, 1, "l1_mis_sh_pulse");
    step();
    op[0] = '0;
    expect_at(0, 1, F_MIS, 0, "l1_mis_pulse_end");
    step();
    op[0] = mk(1, 0, 3'b010, 32'h10, 0, 2);
    expect_at(0, 1, F_MD, 32'h80ADBEEF, "l1_mem_unchanged");
    step();
    op[0] = mk(0, 1, 3'b010, 32'h14, 32'h0, 0);
    step();
    op[0] = mk(0, 1, 3'b001, 32'h16, 32'hA5A51234, 0);
    step();
    op[0] = mk(1, 0, 3'b010, 32'h14, 0, 2);
    expect_at(0, 1, F_MD, 32'h12340000, "l1_sh_upper_lanes");
    step();
    op[0] = mk(0, 1, 3'b010, 32'h418, 32'h5A5A0F0F, 0);
    step();
    op[0] = mk(1, 0, 3'b010, 32'h18, 0, 2);
    expect_at(0, 1, F_MD, 32'h5A5A0F0F, "l1_addr_wrap");
    step();
    op[0] = '0;
    op[0].regwrite = 1'b1; op[0].alures = 32'd7; op[0].rd = 5'd5;
    expect_at(0, 0, F_FHELP, 7, "fwd_help");
    expect_at(0, 0, F_FRD,   5, "fwd_rd");
    expect_at(0, 0, F_FRW,   1, "fwd_regwrite");
    expect_at(0, 0, F_FMR,   0, "fwd_memread");
    expect_at(0, 1, F_RDAT,  7, "alu_regdata");
    expect_at(0, 1, F_RD,    5, "alu_rd");
    expect_at(0, 1, F_RW,    1, "alu_regwrite");
    expect_at(0, 1, F_MD,    0, "alu_memdata");
    step();
    op[0] = '0;

    // ---------------- LATENCY = 3 ----------------
    op[1] = mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    expect_at(1, 0, F_STALL, 1, "l3_sw_stall0");
    expect_at(1, 1, F_STALL, 1, "l3_sw_stall1");
    expect_at(1, 2, F_STALL, 0, "l3_sw_stall2");
    step(); step(); step();
    op[1] = mk(1, 0, 3'b010, 32'h10, 0, 7);
    expect_at(1, 0, F_STALL, 1, "l3_lw_stall0");
    expect_at(1, 1, F_STALL, 1, "l3_lw_stall1");
    expect_at(1, 1, F_RW,    0, "l3_lw_bubble1");
    expect_at(1, 1, F_MTR,   0, "l3_lw_bubble_mtr");
    expect_at(1, 2, F_STALL, 0, "l3_lw_stall2");
    expect_at(1, 2, F_RW,    0, "l3_lw_bubble2");
    expect_at(1, 3, F_MD, 32'hDEADBEEF, "l3_lw_data");
    expect_at(1, 3, F_RW,    1, "l3_lw_regwrite");
    expect_at(1, 3, F_RD,    7, "l3_lw_rd");
    step(); step(); step();
    op[1] = mk(0, 1, 3'b010, 32'h20, 32'h11223344, 0);
    step(); step(); step();
    op[1] = mk(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 0);
    step();
    rstn[1] = 1'b0;
    expect_at(1, 0, F_STALL, 0, "l3_rst_stall_forced");
    step();
    rstn[1] = 1'b1;
    op[1] = '0;
    expect_at(1, 0, F_RDAT, 0, "l3_rst_regdata");
    expect_at(1, 0, F_RW,   0, "l3_rst_regwrite");
    expect_at(1, 0, F_STALL, 0, "l3_rst_stall_after");
    step();
    op[1] = mk(1, 0, 3'b010, 32'h20, 0, 8);
    expect_at(1, 3, F_MD, 32'h11223344, "l3_store_aborted");
    step(); step(); step();
    op[1] = mk(1, 0, 3'b010, 32'h10, 0, 9);
    expect_at(1, 0, F_STALL, 1, "l3_en_stall0");
    step();
    en[1] = 1'b0;
    expect_at(1, 0, F_STALL, 1, "l3_en_frozen_stall1");
    step();
    expect_at(1, 0, F_STALL, 1, "l3_en_frozen_stall2");
    step();
    en[1] = 1'b1;
    expect_at(1, 0, F_STALL, 1, "l3_en_resume_stall");
    expect_at(1, 0, F_RW,    0, "l3_en_frozen_wb");
    expect_at(1, 1, F_STALL, 0, "l3_en_last_cycle");
    expect_at(1, 1, F_RW,    0, "l3_en_not_done");
    expect_at(1, 2, F_MD, 32'hDEADBEEF, "l3_en_data");
    expect_at(1, 2, F_RW,    1, "l3_en_regwrite");
    expect_at(1, 2, F_RD,    9, "l3_en_rd");
    step(); step();
    op[1] = '0;
    step(); step(); step();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
Parametrised successor of the single-cycle MEM pipeline stage. It sits between the EX/MEM and MEM/WB pipeline registers and owns the data memory. It adds byte/halfword/word loads and stores with sign/zero extension, misalignment detection, and a configurable multi-cycle memory latency. While an access is in flight it stalls the pipeline through the hazard detection unit.

Parameters:
XLEN, 32, datapath width in bits (32 only; byte lanes assume 4 bytes/word).
DEPTH_WORDS, 256, number of XLEN-bit words in data memory (power of 2).
LATENCY, 1, cycles per load/store access (>=1; 1 = single-cycle legacy behaviour).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
en  input  1  stage enable; 0 freezes all stage state.
stage_EX_MEM__MEM_regwrite  input  1  writeback enable.
stage_EX_MEM__MEM_memtoreg  input  1  select memory data at WB.
stage_EX_MEM__MEM_memread  input  1  load.
stage_EX_MEM__MEM_memwrite  input  1  store.
stage_EX_MEM__MEM_funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
stage_EX_MEM__MEM_alures  input  XLEN  byte address / ALU result.
stage_EX_MEM__MEM_store_data  input  XLEN  store data, low-aligned.
stage_EX_MEM__MEM_rd_id  input  5  destination register.
MEM__HDUbr_memread  output  1  combinational copy of memread.
MEM__EX_for_help  output  XLEN  combinational copy of alures (forwarding).
MEM__FUbr_rd_id  output  5  combinational copy of rd_id.
MEM__FU_FUbr_regwrite  output  1  combinational copy of regwrite.
MEM__HDU_stall  output  1  access in flight; upstream holds EX/MEM inputs stable.
MEM__misalign  output  1  registered one-cycle pulse on a misaligned access.
stage_MEM_WB__WB_memtoreg  output  1  registered.
stage_MEM_WB__WB_regwrite  output  1  registered.
stage_MEM_WB__WB_memdata  output  XLEN  registered, extended load data.
stage_MEM_WB__WB_regdata  output  XLEN  registered alures.
stage_MEM_WB__WB_rd_id  output  5  registered.

Behaviour:
- Reset (rst_n=0 at an edge): all registered outputs 0, FSM IDLE, counter 0. MEM__HDU_stall forced 0 while rst_n=0. A pending store is aborted with no write. Memory contents are not reset.
- memop = en & (memread | memwrite). Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. funct3 011/110/111 are treated as W.
- Word index = alures[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
- FSM IDLE/BUSY with counter cnt:
  - Non-memory op, or misaligned op, in IDLE with en=1: one-cycle pass-through with no stall.
  - Aligned memop in IDLE: if LATENCY=1, completes at this edge. Otherwise stall=1 combinationally, go to BUSY, cnt=1.
  - In BUSY, stall=1 while cnt<LATENCY-1, and cnt increments each cycle. In the cycle where cnt=LATENCY-1, stall=0 and the access completes at the closing edge; FSM returns to IDLE.
  - Total cycles per access = LATENCY; stall is high for LATENCY-1 of them.
- Completion edge:
  - Store writes only its enabled byte lanes: SB lane=addr[1:0], SH lanes addr[1]*2..+1, SW all lanes.
  - Load reads the addressed word, selects the byte/half, then sign-extends (B/H) or zero-extends (BU/HU).
  - The write and the read occur at the same edge; a back-to-back load sees the prior store.
- MEM/WB register:
  - Captures all fields when en=1 and stall=0.
  - While stall=1 it loads a bubble: regwrite=0, memtoreg=0, other fields hold.
  - For a misaligned access: no memory write, memdata=0, regwrite forced 0, MEM__misalign=1 for one cycle.
  - Non-load memdata=0.
- en=0: FSM, counter, MEM/WB register and memory all frozen; stall holds its registered-state value.
- Forwarding/HDU copies are purely combinational and independent of en and stall.

Test Plan:
- LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> next cycle WB_memdata=0xDEADBEEF, stall never asserted.
- LATENCY=3: LW 0x10 -> stall high 2 cycles; WB_regwrite=0 during stall; WB_memdata=0xDEADBEEF with regwrite=1 after the 3rd edge.
- Sub-word: SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80AD.
- Misaligned LW 0x11 -> MEM__misalign pulse, no stall, WB_regwrite=0, memdata=0; memory unchanged.
- LATENCY=3: rst_n=0 during the 2nd cycle of SW 0x20 -> stall drops and outputs are 0 next cycle; a later LW 0x20 returns the old value.
- en=0 mid-BUSY for 2 cycles -> cnt frozen; the access completes 2 cycles later. An ALU op with rd=5 and alures=7 passes to WB_regdata=7 in one cycle, and the forwarding ports show the input values combinationally.
